// File: rtl/queue_fifo_pkg.sv
// Shared constants and helpers for the lab queue/stack family.
// Defaults live here so the stack variant and the FIFO stay in step.
package queue_fifo_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultAddrW = $clog2(DefaultDepth);

  // Encoded as {push_accepted, pop_accepted}.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } op_e;

  function automatic op_e classify_op(input logic push_acc, input logic pop_acc);
    op_e op;
    unique case ({push_acc, pop_acc})
      2'b00:   op = OpNone;
      2'b01:   op = OpPop;
      2'b10:   op = OpPush;
      default: op = OpBoth;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/queue_fifo_if.sv
// Producer/consumer handshake bundle for queue_fifo.
// The master side drives push/pop/write_data; the slave side is the queue itself.
interface queue_fifo_if import queue_fifo_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = DefaultDepth
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push,
    output pop,
    output write_data,
    input  read_data,
    input  empty,
    input  full,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  push,
    input  pop,
    input  write_data,
    output read_data,
    output empty,
    output full,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/queue_fifo_ram.sv
// DEPTH x DATA_W storage array: synchronous write, asynchronous read.
// Deliberately unreset so it maps onto plain register or LUT storage.
module queue_fifo_ram import queue_fifo_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = DefaultDepth,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/queue_fifo.sv
// Byte FIFO: circular buffer with read/write pointers, occupancy count,
// full/empty flags, a registered read_data and one-cycle misuse pulses.
module queue_fifo import queue_fifo_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = DefaultDepth
) (
  input  logic         clk,
  input  logic         reset,
  queue_fifo_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              empty;
  logic              full;
  logic              push_acc;
  logic              pop_acc;
  logic [DATA_W-1:0] ram_rdata;
  op_e               op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_acc = bus.push & (~full | bus.pop);
  assign pop_acc  = bus.pop & ~empty;
  assign op       = classify_op(push_acc, pop_acc);

  queue_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.write_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    read_data_d = read_data_q;
    overflow_d  = bus.push & full & ~bus.pop;
    underflow_d = bus.pop & empty;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    // Async RAM read sees the old slot even when a full push+pop overwrites it this edge.
    if (pop_acc) begin
      rd_ptr_d    = rd_ptr_q + PtrOne;
      read_data_d = ram_rdata;
    end

    unique case (op)
      OpPush:  count_d = count_q + CountOne;
      OpPop:   count_d = count_q - CountOne;
      OpBoth:  count_d = count_q;
      OpNone:  count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_queue_fifo.sv
// Directed bench for queue_fifo: ordering, overflow/underflow, full push+pop,
// pointer wrap and asynchronous reset, with hand-computed expectations.
module tb_queue_fifo;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  queue_fifo_if bus ();

  queue_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are stable 1 ns after the edge on return.
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    bus.push       = p;
    bus.pop        = q;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.write_data = 8'h00;
    #30;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_rdata", bus.read_data, 8'h00);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);

    // Fill then drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("fill_count", bus.count, i);
    end
    chk("fill_full", bus.full, 1);
    chk("fill_empty", bus.empty, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_rdata", bus.read_data, i);
      chk("drain_count", bus.count, 8 - i);
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_full", bus.full, 0);

    // Overflow while full
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h20 + i));
    end
    step(1'b1, 1'b0, 8'h09);
    chk("ovf_pulse", bus.overflow, 1);
    chk("ovf_count", bus.count, 8);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", bus.overflow, 0);
    chk("ovf_count2", bus.count, 8);

    // Push+pop while full
    step(1'b1, 1'b1, 8'hAA);
    chk("fpp_rdata", bus.read_data, 8'h21);
    chk("fpp_count", bus.count, 8);
    chk("fpp_ovf", bus.overflow, 0);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("fpp_drain", bus.read_data, 8'h20 + i);
    end
    step(1'b0, 1'b1, 8'h00);
    chk("fpp_last", bus.read_data, 8'hAA);
    chk("fpp_empty", bus.empty, 1);

    // Underflow, and push+pop while empty
    step(1'b0, 1'b1, 8'h00);
    chk("udf_pulse", bus.underflow, 1);
    chk("udf_hold", bus.read_data, 8'hAA);
    chk("udf_count", bus.count, 0);
    step(1'b0, 1'b0, 8'h00);
    chk("udf_clear", bus.underflow, 0);
    step(1'b1, 1'b1, 8'h55);
    chk("epp_udf", bus.underflow, 1);
    chk("epp_count", bus.count, 1);
    chk("epp_hold", bus.read_data, 8'hAA);
    step(1'b0, 1'b1, 8'h00);
    chk("epp_rdata", bus.read_data, 8'h55);
    chk("epp_count2", bus.count, 0);
    chk("epp_udf2", bus.underflow, 0);

    // Pointer wrap with alternating push/pop
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'(8'h10 + i));
      chk("wrap_cnt_push", bus.count, 1);
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_rdata", bus.read_data, 8'h10 + i);
      chk("wrap_cnt_pop", bus.count, 0);
    end

    // Asynchronous reset mid-stream
    step(1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b0, 8'h78);
    chk("mid_count", bus.count, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_rdata", bus.read_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 8'h00);
    chk("post_udf", bus.underflow, 1);
    chk("post_rdata", bus.read_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
